// File: rtl/mcycle_pkg.sv
// Shared definitions for the multiply-cycle controller: state encoding and default limits.
package mcycle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_BUSY = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_MAX_CYCLES  = 40;
  localparam int DEF_ARM_TIMEOUT = 4;

  // The multiplier owns the shared adder only while it is armed or running.
  function automatic logic mul_owns_adder(input state_t s);
    return (s == ST_ARM) || (s == ST_BUSY);
  endfunction

endpackage

// File: rtl/adder_share_mux.sv
// Combinational 2:1 selector of {A, B, Cin} in front of a shared adder; i_sel=1 picks client 1.
module adder_share_mux #(
  parameter int WIDTH = 32
) (
  input  logic             i_sel,
  input  logic [WIDTH-1:0] i_a0,
  input  logic [WIDTH-1:0] i_b0,
  input  logic             i_cin0,
  input  logic [WIDTH-1:0] i_a1,
  input  logic [WIDTH-1:0] i_b1,
  input  logic             i_cin1,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic             o_cin
);

  assign o_a   = i_sel ? i_a1   : i_a0;
  assign o_b   = i_sel ? i_b1   : i_b0;
  assign o_cin = i_sel ? i_cin1 : i_cin0;

endmodule

// File: rtl/mcycle_ctrl.sv
// Sequences the iterative multiplier for execute: latches operands, holds MUL_EN, watches Busy
// with timeouts, captures the product and stalls the pipeline; also owns the shared adder mux.
module mcycle_ctrl
  import mcycle_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
  parameter int ARM_TIMEOUT = DEF_ARM_TIMEOUT
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             MULOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic             Stall,
  output logic             Done,
  output logic             Error,
  output logic [WIDTH-1:0] Result,
  output logic             MUL_EN,
  output logic             MUL_Op,
  output logic [WIDTH-1:0] MUL_Op1,
  output logic [WIDTH-1:0] MUL_Op2,
  input  logic [WIDTH-1:0] MUL_Result,
  input  logic             MUL_Busy,
  input  logic [WIDTH-1:0] ALU_AddInA,
  input  logic [WIDTH-1:0] ALU_AddInB,
  input  logic             ALU_Cin,
  input  logic [WIDTH-1:0] M_AddInA,
  input  logic [WIDTH-1:0] M_AddInB,
  input  logic             M_Cin,
  output logic [WIDTH-1:0] AddInA,
  output logic [WIDTH-1:0] AddInB,
  output logic             AddCin
);

  localparam int TW = $clog2(MAX_CYCLES + 1);
  localparam logic [TW-1:0] ARM_LAST  = TW'(ARM_TIMEOUT - 1);
  localparam logic [TW-1:0] BUSY_LAST = TW'(MAX_CYCLES - 1);

  state_t           r_state;
  logic [TW-1:0]    r_timer;
  logic             r_mul_en;
  logic             r_done;
  logic             r_error;
  logic [WIDTH-1:0] r_result;
  logic             r_op;
  logic [WIDTH-1:0] r_op1;
  logic [WIDTH-1:0] r_op2;

  logic             w_stall;
  logic             w_sel_mul;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      r_mul_en <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_result <= '0;
      r_op     <= 1'b0;
      r_op1    <= '0;
      r_op2    <= '0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_op     <= MULOp;
            r_op1    <= Operand1;
            r_op2    <= Operand2;
            r_mul_en <= 1'b1;
            r_timer  <= '0;
            r_state  <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (MUL_Busy) begin
            r_timer <= '0;
            r_state <= ST_BUSY;
          end else if (r_timer == ARM_LAST) begin
            r_timer  <= '0;
            r_mul_en <= 1'b0;
            r_done   <= 1'b1;
            r_error  <= 1'b1;
            r_result <= '0;
            r_state  <= ST_ERR;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_BUSY: begin
          // Busy falling is the multiplier's completion handshake.
          if (!MUL_Busy) begin
            r_result <= MUL_Result;
            r_timer  <= '0;
            r_mul_en <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end else if (r_timer == BUSY_LAST) begin
            r_timer  <= '0;
            r_mul_en <= 1'b0;
            r_done   <= 1'b1;
            r_error  <= 1'b1;
            r_result <= '0;
            r_state  <= ST_ERR;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_DONE, ST_ERR: begin
          // Start is still high for the retiring instruction; IDLE is the guaranteed MUL_EN-low gap.
          r_timer <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_timer  <= '0;
          r_mul_en <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      ST_IDLE: w_stall = Start;
      ST_ARM,
      ST_BUSY: w_stall = 1'b1;
      default: w_stall = 1'b0;
    endcase
  end

  assign w_sel_mul = mul_owns_adder(r_state);

  adder_share_mux #(
    .WIDTH (WIDTH)
  ) u_adder_mux (
    .i_sel  (w_sel_mul),
    .i_a0   (ALU_AddInA),
    .i_b0   (ALU_AddInB),
    .i_cin0 (ALU_Cin),
    .i_a1   (M_AddInA),
    .i_b1   (M_AddInB),
    .i_cin1 (M_Cin),
    .o_a    (AddInA),
    .o_b    (AddInB),
    .o_cin  (AddCin)
  );

  assign Stall   = w_stall;
  assign Done    = r_done;
  assign Error   = r_error;
  assign Result  = r_result;
  assign MUL_EN  = r_mul_en;
  assign MUL_Op  = r_op;
  assign MUL_Op1 = r_op1;
  assign MUL_Op2 = r_op2;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed bench for mcycle_ctrl with a behavioural multiplier stub (normal, stuck-busy, never-busy).
module tb_mcycle_ctrl;

  localparam int W = 32;

  logic          CLK = 1'b0;
  logic          Reset;
  logic          Start;
  logic          MULOp;
  logic [W-1:0]  Operand1, Operand2;
  logic          Stall, Done, Error;
  logic [W-1:0]  Result;
  logic          MUL_EN, MUL_Op;
  logic [W-1:0]  MUL_Op1, MUL_Op2;
  logic [W-1:0]  MUL_Result;
  logic          MUL_Busy;
  logic [W-1:0]  ALU_AddInA, ALU_AddInB;
  logic          ALU_Cin;
  logic [W-1:0]  M_AddInA, M_AddInB;
  logic          M_Cin;
  logic [W-1:0]  AddInA, AddInB;
  logic          AddCin;

  int n_checks = 0;
  int n_err    = 0;

  // Stub modes: 0 = busy for stub_n cycles, 1 = busy forever, 2 = never busy.
  int   stub_mode = 0;
  int   stub_n    = 1;
  int   stub_cnt;
  logic stub_fired;

  mcycle_ctrl dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .Start      (Start),
    .MULOp      (MULOp),
    .Operand1   (Operand1),
    .Operand2   (Operand2),
    .Stall      (Stall),
    .Done       (Done),
    .Error      (Error),
    .Result     (Result),
    .MUL_EN     (MUL_EN),
    .MUL_Op     (MUL_Op),
    .MUL_Op1    (MUL_Op1),
    .MUL_Op2    (MUL_Op2),
    .MUL_Result (MUL_Result),
    .MUL_Busy   (MUL_Busy),
    .ALU_AddInA (ALU_AddInA),
    .ALU_AddInB (ALU_AddInB),
    .ALU_Cin    (ALU_Cin),
    .M_AddInA   (M_AddInA),
    .M_AddInB   (M_AddInB),
    .M_Cin      (M_Cin),
    .AddInA     (AddInA),
    .AddInB     (AddInB),
    .AddCin     (AddCin)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      MUL_Busy   <= 1'b0;
      MUL_Result <= '0;
      stub_fired <= 1'b0;
      stub_cnt   <= 0;
    end else if (!MUL_EN) begin
      MUL_Busy   <= 1'b0;
      stub_fired <= 1'b0;
    end else if (!stub_fired) begin
      stub_fired <= 1'b1;
      if (stub_mode != 2) begin
        MUL_Busy   <= 1'b1;
        stub_cnt   <= stub_n;
        MUL_Result <= MUL_Op1 * MUL_Op2;
      end
    end else if (MUL_Busy && stub_mode == 0) begin
      if (stub_cnt == 1) MUL_Busy <= 1'b0;
      stub_cnt <= stub_cnt - 1;
    end
  end

  typedef struct {
    logic       op;
    logic [W-1:0] a, b;
    logic [W-1:0] a2, b2;
    int         mode;
    int         n;
    logic [W-1:0] exp_res;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_op(input vec_t v);
    int lat;
    stub_mode = v.mode;
    stub_n    = v.n;
    @(negedge CLK);
    MULOp = v.op; Operand1 = v.a; Operand2 = v.b; Start = 1'b1;
    #1 check("stall_accept", 32'(Stall), 32'd1);
    @(negedge CLK);
    lat = 0;
    check("mul_en_arm", 32'(MUL_EN), 32'd1);
    check("stall_arm", 32'(Stall), 32'd1);
    check("addA_arm", AddInA, M_AddInA);
    check("addB_arm", AddInB, M_AddInB);
    check("addC_arm", 32'(AddCin), 32'(M_Cin));
    Operand1 = v.a2; Operand2 = v.b2; MULOp = ~v.op;
    while (!Done) begin
      @(negedge CLK);
      lat++;
      if (lat == 1) begin
        check("op1_latched", MUL_Op1, v.a);
        check("op2_latched", MUL_Op2, v.b);
        check("op_latched", 32'(MUL_Op), 32'(v.op));
      end
      if (lat == 2 && v.mode != 2) begin
        M_AddInA = 32'h0F0F_0F0F; M_AddInB = 32'h0000_0001; M_Cin = 1'b1;
        #1;
        check("addA_busy", AddInA, 32'h0F0F_0F0F);
        check("addB_busy", AddInB, 32'h0000_0001);
        check("addC_busy", 32'(AddCin), 32'd1);
        M_AddInA = 32'hAAAA_5555; M_AddInB = 32'h1234_5678; M_Cin = 1'b0;
      end
      if (lat > 200) begin
        n_checks++; n_err++;
        $display("FAIL done_timeout: no Done after %0d cycles, expected %0d", lat, v.exp_lat);
        break;
      end
    end
    check("latency", 32'(lat), 32'(v.exp_lat));
    check("result", Result, v.exp_res);
    check("error", 32'(Error), 32'(v.exp_err));
    check("mul_en_done", 32'(MUL_EN), 32'd0);
    check("stall_done", 32'(Stall), 32'd0);
    Start = 1'b0;
    @(negedge CLK);
    check("done_pulse", 32'(Done), 32'd0);
    check("error_pulse", 32'(Error), 32'd0);
    check("mul_en_idle", 32'(MUL_EN), 32'd0);
    check("result_hold", Result, v.exp_res);
    check("addA_idle", AddInA, ALU_AddInA);
    check("addB_idle", AddInB, ALU_AddInB);
    check("addC_idle", 32'(AddCin), 32'(ALU_Cin));
  endtask

  initial begin
    // op, a, b, a2, b2, mode, n, exp_res, exp_err, exp_lat
    vecs[0] = '{1'b0, 32'h2, 32'h2, 32'h7, 32'h9, 0, 3, 32'h0000_0004, 1'b0, 5};
    vecs[1] = '{1'b0, 32'h3, 32'h5, 32'h1, 32'h1, 1, 1, 32'h0000_0000, 1'b1, 42};
    vecs[2] = '{1'b1, 32'h2, 32'hFFFF_FFFE, 32'h1234, 32'h5678, 0, 5, 32'hFFFF_FFFC, 1'b0, 7};
    vecs[3] = '{1'b1, 32'h6, 32'h7, 32'h0, 32'h0, 2, 1, 32'h0000_0000, 1'b1, 4};
    vecs[4] = '{1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h3, 32'h3, 0, 1, 32'h0000_0004, 1'b0, 3};

    Reset = 1'b1; Start = 1'b0; MULOp = 1'b0; Operand1 = '0; Operand2 = '0;
    ALU_AddInA = 32'h10; ALU_AddInB = 32'h20; ALU_Cin = 1'b1;
    M_AddInA = 32'hAAAA_5555; M_AddInB = 32'h1234_5678; M_Cin = 1'b0;
    #12;
    check("rst_stall", 32'(Stall), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_error", 32'(Error), 32'd0);
    check("rst_result", Result, 32'd0);
    check("rst_mul_en", 32'(MUL_EN), 32'd0);
    check("rst_op1", MUL_Op1, 32'd0);
    check("rst_addA", AddInA, 32'h10);
    check("rst_addB", AddInB, 32'h20);
    check("rst_addC", 32'(AddCin), 32'd1);
    Start = 1'b1;
    #1 check("rst_stall_start", 32'(Stall), 32'd1);
    Start = 1'b0;
    @(negedge CLK);
    Reset = 1'b0;

    for (int i = 0; i < 5; i++) do_op(vecs[i]);

    // Reset mid-BUSY, between clock edges.
    stub_mode = 0; stub_n = 10;
    @(negedge CLK);
    MULOp = 1'b0; Operand1 = 32'h2; Operand2 = 32'h2; Start = 1'b1;
    repeat (3) @(negedge CLK);
    check("pre_rst_busy", 32'(MUL_Busy), 32'd1);
    check("pre_rst_mul_en", 32'(MUL_EN), 32'd1);
    #2;
    Reset = 1'b1; Start = 1'b0;
    #1;
    check("midrst_mul_en", 32'(MUL_EN), 32'd0);
    check("midrst_stall", 32'(Stall), 32'd0);
    check("midrst_result", Result, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("midrst_no_done", 32'(Done), 32'd0);
    end
    Reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      check("post_rst_no_done", 32'(Done), 32'd0);
    end
    do_op(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
